// File: rtl/prog_sequencer_if.sv
// Sequencer-facing bundle: control/status, program memory read port and processor drive.
// master = sequencer side, slave = environment (memory, processor, host).
interface prog_sequencer_if #(
  parameter int REG_WIDTH  = 16,
  parameter int ADDR_WIDTH = 5
);
  logic                  start;
  logic [ADDR_WIDTH-1:0] prog_len;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [REG_WIDTH-1:0]  mem_data;
  logic [REG_WIDTH-1:0]  cpu_din;
  logic                  cpu_run;
  logic                  cpu_done;
  logic                  busy;
  logic                  finished;
  logic                  err;
  logic [7:0]            instr_count;

  modport master (
    input  start, prog_len, mem_data, cpu_done,
    output mem_addr, cpu_din, cpu_run, busy, finished, err, instr_count
  );

  modport slave (
    output start, prog_len, mem_data, cpu_done,
    input  mem_addr, cpu_din, cpu_run, busy, finished, err, instr_count
  );
endinterface

// File: rtl/prog_sequencer.sv
// Walks a program in synchronous-read memory and feeds it to the processor one instruction at a time.
// MV/MVI take 3 cycles FETCH-to-FETCH, ADD/SUB 5; a watchdog aborts any instruction that never signals done.
module prog_sequencer #(
  parameter int REG_WIDTH         = 16,
  parameter int INSTRUCTION_WIDTH = 9,
  parameter int ADDR_WIDTH        = 5,
  parameter int WDOG_CYCLES       = 8
) (
  input  logic               clk,
  input  logic               rst,
  prog_sequencer_if.master   bus
);

  localparam int PC_W = ADDR_WIDTH + 1;
  localparam int WD_W = $clog2(WDOG_CYCLES + 1);
  localparam logic [2:0] OP_MVI = 3'b001;
  localparam logic [WD_W-1:0] WDOG_LAST = WD_W'(WDOG_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    ISSUE,
    EXEC,
    FIN
  } state_t;

  state_t                state, state_nxt;
  logic [PC_W-1:0]       pc, pc_nxt;
  logic [ADDR_WIDTH-1:0] len, len_nxt;
  logic [REG_WIDTH-1:0]  instr, instr_nxt;
  logic [WD_W-1:0]       wdog, wdog_nxt;
  logic                  err_q, err_nxt;
  logic [7:0]            cnt, cnt_nxt;

  logic [ADDR_WIDTH-1:0] mem_addr_c;
  logic [REG_WIDTH-1:0]  cpu_din_c;
  logic                  cpu_run_c;

  // pc carries one extra bit so pc+1 / pc+2 past the top address compare correctly
  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] pc_step;
  logic [PC_W-1:0] len_ext;
  logic            issue_mvi;
  logic            exec_mvi;

  assign pc_inc    = pc + PC_W'(1);
  assign len_ext   = {1'b0, len};
  assign issue_mvi = (bus.mem_data[INSTRUCTION_WIDTH-1 -: 3] == OP_MVI);
  assign exec_mvi  = (instr[INSTRUCTION_WIDTH-1 -: 3] == OP_MVI);
  assign pc_step   = pc + (exec_mvi ? PC_W'(2) : PC_W'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      pc    <= '0;
      len   <= '0;
      instr <= '0;
      wdog  <= '0;
      err_q <= 1'b0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      len   <= len_nxt;
      instr <= instr_nxt;
      wdog  <= wdog_nxt;
      err_q <= err_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    pc_nxt     = pc;
    len_nxt    = len;
    instr_nxt  = instr;
    wdog_nxt   = wdog;
    err_nxt    = err_q;
    cnt_nxt    = cnt;
    mem_addr_c = '0;
    cpu_din_c  = '0;
    cpu_run_c  = 1'b0;

    unique case (state)
      IDLE: begin
        if (bus.start) begin
          len_nxt   = bus.prog_len;
          pc_nxt    = '0;
          cnt_nxt   = '0;
          err_nxt   = 1'b0;
          state_nxt = (bus.prog_len == '0) ? FIN : FETCH;
        end
      end

      FETCH: begin
        mem_addr_c = pc[ADDR_WIDTH-1:0];
        state_nxt  = ISSUE;
      end

      ISSUE: begin
        // Pointing at pc+1 now makes the MVI immediate visible from the first EXEC cycle.
        mem_addr_c = pc_inc[ADDR_WIDTH-1:0];
        cpu_din_c  = bus.mem_data;
        instr_nxt  = bus.mem_data;
        wdog_nxt   = '0;
        if (issue_mvi && (pc_inc >= len_ext)) begin
          err_nxt   = 1'b1;
          state_nxt = FIN;
        end else begin
          cpu_run_c = 1'b1;
          state_nxt = EXEC;
        end
      end

      EXEC: begin
        mem_addr_c = pc_inc[ADDR_WIDTH-1:0];
        cpu_run_c  = 1'b1;
        cpu_din_c  = exec_mvi ? bus.mem_data : instr;
        if (bus.cpu_done) begin
          pc_nxt    = pc_step;
          cnt_nxt   = cnt + 8'd1;
          state_nxt = (pc_step >= len_ext) ? FIN : FETCH;
        end else if (wdog == WDOG_LAST) begin
          err_nxt   = 1'b1;
          state_nxt = FIN;
        end else begin
          wdog_nxt = wdog + WD_W'(1);
        end
      end

      FIN: begin
        state_nxt = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Outputs decode straight from state so an asserted rst clears them without waiting for a clock.
  assign bus.mem_addr    = mem_addr_c;
  assign bus.cpu_din     = cpu_din_c;
  assign bus.cpu_run     = cpu_run_c;
  assign bus.busy        = (state != IDLE);
  assign bus.finished    = (state == FIN);
  assign bus.err         = err_q;
  assign bus.instr_count = cnt;

endmodule

// File: tb/tb_prog_sequencer.sv
// Bench for prog_sequencer: program memory, a small step-based processor model and a decoupled scoreboard.
module tb_prog_sequencer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  prog_sequencer_if #(.REG_WIDTH(16), .ADDR_WIDTH(5)) bus ();

  prog_sequencer #(
    .REG_WIDTH(16), .INSTRUCTION_WIDTH(9), .ADDR_WIDTH(5), .WDOG_CYCLES(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Program memory, synchronous read
  logic [15:0] mem [32];
  always @(posedge clk) bus.mem_data <= mem[bus.mem_addr];

  // Processor model: step counter t held at 0 while run is low; MV/MVI finish at t1, ADD/SUB at t3
  logic [15:0] r [8] = '{default: 16'h0};
  logic [15:0] ir = 16'h0, a_reg = 16'h0, g_reg = 16'h0;
  int          t = 0;
  logic        kill_done = 1'b0;
  logic        p_done;
  logic [15:0] p_bus;

  always_comb begin
    p_done = 1'b0;
    p_bus  = 16'h0;
    case (ir[8:6])
      3'd0: if (t == 1) begin p_done = 1'b1; p_bus = r[ir[2:0]]; end
      3'd1: if (t == 1) begin p_done = 1'b1; p_bus = bus.cpu_din; end
      3'd2, 3'd3: if (t == 3) begin p_done = 1'b1; p_bus = g_reg; end
      default: ;
    endcase
  end
  assign bus.cpu_done = p_done & ~kill_done;

  always @(posedge clk) begin
    if (!bus.cpu_run) begin
      t <= 0;
    end else if (t == 0) begin
      ir <= bus.cpu_din;
      t  <= 1;
    end else begin
      if (ir[8:6] == 3'd2 || ir[8:6] == 3'd3) begin
        if (t == 1) a_reg <= r[ir[5:3]];
        else if (t == 2) g_reg <= (ir[8:6] == 3'd2) ? a_reg + r[ir[2:0]] : a_reg - r[ir[2:0]];
      end
      if (bus.cpu_done) begin
        t <= 0;
        r[ir[5:3]] <= p_bus;
      end else begin
        t <= t + 1;
      end
    end
  end

  // Scoreboard
  typedef struct packed {
    logic [7:0] cnt;
    logic       err;
  } fin_t;

  logic [15:0] bus_q [$];
  fin_t        fin_q [$];
  int          rise_q [$];
  int n_cmp = 0, n_bad = 0;
  int cyc = 0, run_cycles = 0, fin_cnt = 0;
  logic prev_run = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc++;

  always @(negedge clk) begin : monitor
    fin_t e;
    if (!rst) begin
      if (bus.cpu_run) run_cycles++;
      if (bus.cpu_run && !prev_run) rise_q.push_back(cyc);
      if (bus.cpu_run && bus.cpu_done) begin
        if (bus_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL bus_unexpected: got done with bus 0x%0h, expected no done", p_bus);
        end else begin
          chk("bus_at_done", 32'(p_bus), 32'(bus_q.pop_front()));
        end
      end
      if (bus.finished) begin
        fin_cnt++;
        if (fin_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL finished_unexpected: got finished pulse, expected none");
        end else begin
          e = fin_q.pop_front();
          chk("instr_count", 32'(bus.instr_count), 32'(e.cnt));
          chk("err", 32'(bus.err), 32'(e.err));
        end
      end
    end
    prev_run = bus.cpu_run;
  end

  // Stimulus helpers
  task automatic load(input logic [15:0] p [8]);
    for (int i = 0; i < 32; i++) mem[i] = (i < 8) ? p[i] : 16'h0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_mem_addr"}, 32'(bus.mem_addr), 0);
    chk({tag, "_cpu_din"}, 32'(bus.cpu_din), 0);
    chk({tag, "_cpu_run"}, 32'(bus.cpu_run), 0);
    chk({tag, "_busy"}, 32'(bus.busy), 0);
    chk({tag, "_finished"}, 32'(bus.finished), 0);
    chk({tag, "_err"}, 32'(bus.err), 0);
    chk({tag, "_instr_count"}, 32'(bus.instr_count), 0);
  endtask

  task automatic start_prog(input logic [4:0] len);
    run_cycles = 0;
    rise_q.delete();
    @(negedge clk);
    bus.prog_len = len;
    bus.start    = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    @(negedge clk);
    chk("busy_after_start", 32'(bus.busy), 1);
    chk("finished_first_cycle", 32'(bus.finished), 32'(len == 5'd0));
  endtask

  task automatic wait_fin(input int base);
    for (int i = 0; i < 300; i++) begin
      if (fin_cnt != base) break;
      @(posedge clk);
    end
    if (fin_cnt == base) begin
      n_cmp++; n_bad++;
      $display("FAIL finish_timeout: got no finished pulse, expected one within 300 cycles");
    end
    repeat (2) @(negedge clk);
    chk("bus_q_drained", 32'(bus_q.size()), 0);
    chk("fin_q_drained", 32'(fin_q.size()), 0);
  endtask

  task automatic run_prog(input logic [4:0] len);
    int base;
    base = fin_cnt;
    start_prog(len);
    wait_fin(base);
  endtask

  initial begin
    int base;
    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.prog_len = 5'd0;
    load('{16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0});
    repeat (2) @(negedge clk);
    chk_reset("reset");
    rst = 1'b0;

    // MVI R0,5 ; MV R1,R0
    load('{16'h0040, 16'h0005, 16'h0008, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0});
    bus_q.push_back(16'h0005);
    bus_q.push_back(16'h0005);
    fin_q.push_back('{cnt: 8'd2, err: 1'b0});
    run_prog(5'd3);
    chk("mvi_fetch_to_fetch", 32'(rise_q[1] - rise_q[0]), 3);

    // MVI R4,5 ; MVI R5,3 ; ADD R4,R5 ; SUB R4,R5 -- a stray start and prog_len change mid-run must be ignored
    load('{16'h0060, 16'h0005, 16'h0068, 16'h0003, 16'h00A5, 16'h00E5, 16'h0, 16'h0});
    bus_q.push_back(16'h0005);
    bus_q.push_back(16'h0003);
    bus_q.push_back(16'h0008);
    bus_q.push_back(16'h0005);
    fin_q.push_back('{cnt: 8'd4, err: 1'b0});
    base = fin_cnt;
    start_prog(5'd6);
    repeat (3) @(negedge clk);
    bus.prog_len = 5'd1;
    bus.start    = 1'b1;
    @(negedge clk);
    bus.start    = 1'b0;
    wait_fin(base);
    chk("issue_count", 32'(rise_q.size()), 4);
    chk("add_fetch_to_fetch", 32'(rise_q[3] - rise_q[2]), 5);
    chk("mvi2_fetch_to_fetch", 32'(rise_q[2] - rise_q[1]), 3);

    // Empty program
    fin_q.push_back('{cnt: 8'd0, err: 1'b0});
    run_prog(5'd0);
    chk("len0_run_cycles", 32'(run_cycles), 0);

    // MV R1,R0 ; MVI R2 with its immediate cut off
    load('{16'h0008, 16'h0050, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0});
    bus_q.push_back(16'h0005);
    fin_q.push_back('{cnt: 8'd1, err: 1'b1});
    run_prog(5'd2);
    chk("trunc_run_cycles", 32'(run_cycles), 2);

    // Processor never signals done: watchdog
    kill_done = 1'b1;
    load('{16'h0008, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0});
    fin_q.push_back('{cnt: 8'd0, err: 1'b1});
    run_prog(5'd1);
    chk("wdog_run_cycles", 32'(run_cycles), 9);
    kill_done = 1'b0;

    // Reset in the middle of ADD R4,R5
    load('{16'h00A5, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0});
    start_prog(5'd1);
    for (int i = 0; i < 20 && !bus.cpu_run; i++) @(negedge clk);
    chk("add_issued", 32'(bus.cpu_run), 1);
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 chk_reset("midexec");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Rerun from address 0 after the reset: MVI R0,9
    load('{16'h0040, 16'h0009, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0});
    bus_q.push_back(16'h0009);
    fin_q.push_back('{cnt: 8'd1, err: 1'b0});
    run_prog(5'd2);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/prog_sequencer.md
PROG_SEQUENCER -- requirements
Module: prog_sequencer

Interface
REQ-001 Parameter REG_WIDTH, default 16, width of processor data word and program memory word.
REQ-002 Parameter INSTRUCTION_WIDTH, default 9, instruction field width in bits [8:0]: opcode[8:6], dest[5:3], src[2:0].
REQ-003 Parameter ADDR_WIDTH, default 5, program memory address width.
REQ-004 Parameter WDOG_CYCLES, default 8, max EXEC cycles awaiting cpu_done.
REQ-005 clk  in  1  single clock; all state changes on rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 start  in  1  begin executing program from address 0; sampled only in IDLE.
REQ-008 prog_len  in  ADDR_WIDTH  program length in words; latched on accepted start.
REQ-009 mem_addr  out  ADDR_WIDTH  program memory read address.
REQ-010 mem_data  in  REG_WIDTH  memory read data, valid the cycle after mem_addr is driven (synchronous read).
REQ-011 cpu_din  out  REG_WIDTH  drives processor din.
REQ-012 cpu_run  out  1  drives processor run; processor step counter holds t0 while low.
REQ-013 cpu_done  in  1  processor done, high in the final step of each instruction.
REQ-014 busy  out  1  high in any state other than IDLE.
REQ-015 finished  out  1  one-cycle pulse on program end (normal or error).
REQ-016 err  out  1  sticky error flag, cleared by next accepted start.
REQ-017 instr_count  out  8  instructions completed since last accepted start.

Function
REQ-018 The FSM SHALL have states IDLE, FETCH, ISSUE, EXEC, FIN.
REQ-019 IDLE: start=1 -> latch prog_len, pc=0, instr_count=0, err=0; go FIN if prog_len==0, else FETCH.
REQ-020 FETCH (1 cycle): mem_addr=pc, cpu_run=0; -> ISSUE.
REQ-021 ISSUE (1 cycle): register instr=mem_data; cpu_din=mem_data; cpu_run=1; mem_addr=pc+1.
REQ-022 ISSUE with opcode 001 (MVI) and pc+1 >= prog_len: cpu_run=0 this cycle, err=1, -> FIN (truncated immediate).
REQ-023 EXEC: cpu_run=1; cpu_din=mem_data (immediate) for MVI, held instr word otherwise.
REQ-024 mem_addr SHALL hold pc+1 throughout EXEC so immediate remains valid every EXEC cycle.
REQ-025 EXEC with cpu_done=1: pc += 2 (MVI) or 1 (other); instr_count += 1 (wraps 255->0); -> FIN if new pc >= prog_len, else FETCH.
REQ-026 EXEC watchdog: counter reset on ISSUE entry; after WDOG_CYCLES EXEC cycles without cpu_done, err=1, cpu_run=0, -> FIN.
REQ-027 FIN (1 cycle): finished=1, cpu_run=0; -> IDLE.
REQ-028 Latency: MV/MVI 3 cycles FETCH-to-FETCH, ADD/SUB 5 cycles (done at processor t3).
REQ-029 start while busy SHALL be ignored; prog_len changes after latch have no effect.
REQ-030 pc arithmetic ADDR_WIDTH+1 bits so pc+2 past top address does not wrap before comparison.
REQ-031 cpu_run SHALL be 0 in IDLE, FETCH, FIN, guaranteeing processor at t0 on each ISSUE.

Reset
REQ-032 rst=1 SHALL immediately force IDLE, pc=0, mem_addr=0, cpu_din=0, cpu_run=0, busy=0, finished=0, err=0, instr_count=0, regardless of state.
REQ-033 Reset mid-EXEC SHALL drop cpu_run same cycle; no finished pulse is generated.

Verification
REQ-034 Program [MVI R0; 0x0005; MV R1,R0], prog_len=3 -> processor bus 0x0005 at both done pulses; finished once; instr_count=2; err=0.
REQ-035 Program [MVI R4;0x0005; MVI R5;0x0003; ADD R4,R5; SUB R4,R5], prog_len=6 -> bus 0x0008 then 0x0005 at t3; instr_count=4; ADD spans 5 cycles FETCH-to-FETCH.
REQ-036 prog_len=0, start -> finished pulse 2 cycles later, cpu_run never high, instr_count=0.
REQ-037 Program [MV R1,R0; MVI R2], prog_len=2 -> MV completes, MVI never issued (cpu_run low), err=1, instr_count=1.
REQ-038 cpu_done tied low, prog_len=1 -> cpu_run high exactly 1+WDOG_CYCLES cycles, then err=1, finished pulse.
REQ-039 rst asserted during ADD EXEC -> outputs at reset values before next clock edge; subsequent start reruns from address 0.
